// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - shared constants and state encoding for the mux4 scanner
package mux4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // 2'd3 is unused; the scanner treats it as illegal and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-channel dwell counter; tick marks the sample cycle
module dwell_timer #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  logic [7:0] count;

  assign tick = run && (count == 8'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/mux4_scanner.sv
// rtl/mux4_scanner.sv - steps mux4 select through a..d and assembles a 4-bit scan word
module mux4_scanner
  import mux4_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [3:0]       data,
  output logic             valid,
  output logic [CNT_W-1:0] scan_count
);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != ST_SCAN),
    .run     (state_q == ST_SCAN),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (tick) begin
          case (sel_q)
            2'd0: shadow_d[0] = mux_out;
            2'd1: shadow_d[1] = mux_out;
            2'd2: shadow_d[2] = mux_out;
            default: ;
          endcase
          // Last channel goes straight into data so the word is published whole.
          if (sel_q == SEL_W'(NUM_CH - 1)) begin
            state_d = ST_DONE;
            sel_d   = '0;
            data_d  = {mux_out, shadow_q};
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        sel_d   = '0;
        state_d = (cont || start) ? ST_SCAN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  assign sel        = sel_q;
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign data       = data_q;
  assign valid      = valid_q;
  assign scan_count = cnt_q;

endmodule

// File: tb/tb_mux4_scanner.sv
// tb/tb_mux4_scanner.sv - scoreboard bench for mux4_scanner at DWELL=2/CNT_W=2 and DWELL=1
module tb_mux4_scanner;

  typedef struct {
    logic [3:0] d;
    int         cnt;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q2[$];
  exp_t q1[$];

  // instance A: DWELL=2, CNT_W=2
  logic       rst2 = 1'b0, start2 = 1'b0, cont2 = 1'b0;
  logic [3:0] ch2 = 4'b0;
  logic [1:0] sel2;
  logic       busy2, done2, valid2;
  logic [3:0] data2;
  logic [1:0] cnt2;

  // instance B: DWELL=1, CNT_W=8
  logic       rst1 = 1'b0, start1 = 1'b0, cont1 = 1'b0;
  logic [3:0] ch1 = 4'b0;
  logic [1:0] sel1;
  logic       busy1, done1, valid1;
  logic [3:0] data1;
  logic [7:0] cnt1;

  mux4_scanner #(.DWELL(2), .CNT_W(2)) u_d2 (
    .clk(clk), .reset_n(rst2), .start(start2), .cont(cont2), .mux_out(ch2[sel2]),
    .sel(sel2), .busy(busy2), .done(done2), .data(data2), .valid(valid2), .scan_count(cnt2)
  );

  mux4_scanner #(.DWELL(1), .CNT_W(8)) u_d1 (
    .clk(clk), .reset_n(rst1), .start(start1), .cont(cont1), .mux_out(ch1[sel1]),
    .sel(sel1), .busy(busy1), .done(done1), .data(data1), .valid(valid1), .scan_count(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [3:0] d, input int cnt, input int at);
    exp_t e;
    e.d = d; e.cnt = cnt; e.cyc = at;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        chk("d2_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2_data", data2, e.d);
        chk("d2_count", cnt2, e.cnt);
        chk("d2_done_cycle", cyc, e.cyc);
        chk("d2_valid", valid2, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("d1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("d1_data", data1, e.d);
        chk("d1_count", cnt1, e.cnt);
        chk("d1_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int bad;
    nclk(2);
    rst2 = 1'b1;
    rst1 = 1'b1;

    // reset state and quiet idle
    chk("rst_sel", sel2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_data", data2, 0);
    chk("rst_valid", valid2, 0);
    chk("rst_count", cnt2, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sel2 !== 2'd0 || busy2 !== 1'b0 || done2 !== 1'b0) bad++;
      nclk(1);
    end
    chk("idle_quiet", bad, 0);

    // single scan: a=1 b=0 c=1 d=1
    ch2 = 4'b1101;
    q2.push_back(mk(4'b1101, 1, cyc + 9));
    start2 = 1'b1;
    nclk(1);
    start2 = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (sel2 !== 2'(i / 2) || busy2 !== 1'b1) bad++;
      nclk(1);
    end
    chk("sel_steps", bad, 0);
    nclk(1);
    chk("single_busy_after", busy2, 0);
    chk("single_data", data2, 4'b1101);
    chk("single_valid", valid2, 1);
    chk("single_count", cnt2, 1);

    // extra starts while busy, d toggles while sel=1 and settles back before its sample
    ch2 = 4'b0101;
    q2.push_back(mk(4'b0101, 2, cyc + 9));
    start2 = 1'b1;
    nclk(1);
    start2 = 1'b0;
    nclk(1);
    start2 = 1'b1;
    nclk(1);
    start2 = 1'b0;
    chk("busy_sel1", sel2, 1);
    ch2[3] = 1'b1;
    nclk(1);
    start2 = 1'b1;
    nclk(1);
    start2 = 1'b0;
    ch2[3] = 1'b0;
    nclk(5);
    chk("busy_no_requeue", busy2, 0);
    chk("busy_count", cnt2, 2);

    // reset mid-scan while sel=2: partial scan discarded, no done
    ch2 = 4'b1111;
    start2 = 1'b1;
    nclk(1);
    start2 = 1'b0;
    nclk(4);
    chk("midrst_sel_before", sel2, 2);
    rst2 = 1'b0;
    nclk(1);
    chk("midrst_sel", sel2, 0);
    chk("midrst_data", data2, 0);
    chk("midrst_valid", valid2, 0);
    chk("midrst_busy", busy2, 0);
    chk("midrst_count", cnt2, 0);
    rst2 = 1'b1;
    nclk(3);
    chk("midrst_stays_idle", busy2, 0);

    // counter wrap with CNT_W=2: five back-to-back scans
    ch2 = 4'b0110;
    for (int i = 0; i < 5; i++) q2.push_back(mk(4'b0110, (i + 1) % 4, cyc + 9 + 9 * i));
    cont2 = 1'b1;
    start2 = 1'b1;
    nclk(1);
    start2 = 1'b0;
    nclk(39);
    cont2 = 1'b0;
    nclk(7);
    chk("wrap_idle", busy2, 0);
    chk("wrap_count", cnt2, 1);

    // continuous mode at DWELL=1: done every 5 cycles
    ch1 = 4'b0001;
    q1.push_back(mk(4'b0001, 1, cyc + 5));
    q1.push_back(mk(4'b1000, 2, cyc + 10));
    q1.push_back(mk(4'b1000, 3, cyc + 15));
    cont1 = 1'b1;
    start1 = 1'b1;
    nclk(1);
    start1 = 1'b0;
    nclk(4);
    ch1 = 4'b1000;
    nclk(7);
    cont1 = 1'b0;
    nclk(4);
    chk("cont_idle", busy1, 0);
    chk("cont_data", data1, 4'b1000);

    nclk(2);
    chk("q2_drained", q2.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
